vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_VISIBLE, default 640: visible pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, default 16 / 96 / 48: horizontal front porch, sync and back porch widths in clocks (line total 800).
REQ-003 Parameter V_VISIBLE, default 480: visible lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, default 10 / 2 / 33: vertical front porch, sync and back porch widths in lines (frame total 525).
REQ-005 Parameter PIPE_DELAY, default 1, legal 1..4: register stages applied to hs/vs so they line up with the downstream sprite/palette colour pipeline.
REQ-006 vga_clk  input  1  pixel clock; all logic on its rising edge.
REQ-007 reset_n  input  1  synchronous, active-low reset.
REQ-008 DrawX  output  10  current horizontal counter value; visible when < H_VISIBLE.
REQ-009 DrawY  output  10  current vertical counter value; visible when < V_VISIBLE.
REQ-010 blank  output  1  display enable, high only inside the visible area; name and polarity match what the downstream colour stage consumes.
REQ-011 hs  output  1  horizontal sync, active-low, delayed PIPE_DELAY clocks.
REQ-012 vs  output  1  vertical sync, active-low, delayed PIPE_DELAY clocks.
REQ-013 line_start  output  1  one-clock pulse while DrawX==0.
REQ-014 frame_start  output  1  one-clock pulse while DrawX==0 and DrawY==0.
REQ-015 frame_count  output  16  number of completed frames since reset.

Function
REQ-016 h_cnt increments by 1 each clock; at H_TOTAL-1 (799) it wraps to 0 on the next clock.
REQ-017 v_cnt increments only on the clock where h_cnt wraps; at V_TOTAL-1 (524) with h_cnt at 799 it wraps to 0.
REQ-018 DrawX/DrawY are the registered h_cnt/v_cnt, with zero combinational logic after the register.
REQ-019 blank = (h_cnt < H_VISIBLE) AND (v_cnt < V_VISIBLE), evaluated in the same cycle as DrawX/DrawY, with no delay.
REQ-020 Raw hsync is low for H_VISIBLE+H_FP <= h_cnt < H_VISIBLE+H_FP+H_SYNC (656..751), otherwise high.
REQ-021 Raw vsync is low for V_VISIBLE+V_FP <= v_cnt < V_VISIBLE+V_FP+V_SYNC (490..491) for the whole line, otherwise high.
REQ-022 hs/vs pass through a PIPE_DELAY-deep shift register, so hs at cycle t equals raw hsync at cycle t-PIPE_DELAY.
REQ-023 line_start and frame_start are decoded from the counters in the same cycle as DrawX/DrawY; there is no extra latency.
REQ-024 frame_count increments by 1 on the clock where (h_cnt,v_cnt) goes from (799,524) to (0,0), and wraps 65535 -> 0.
REQ-025 Sync stays internally consistent at wrap: exactly one hs low pulse of H_SYNC clocks per line and exactly one vs low pulse of V_SYNC lines per frame.

Reset
REQ-026 While reset_n is low at a rising edge, outputs take these values:
- h_cnt=0, v_cnt=0, DrawX=0, DrawY=0.
- blank=0, line_start=0, frame_start=0 (all forced low during reset).
- frame_count=0.
- hs=1, vs=1, and every delay stage=1.
REQ-027 On the first clock after reset_n returns high, the outputs are:
- DrawX=0, DrawY=0.
- blank=1.
- line_start=1, frame_start=1.
- frame_count=0.
REQ-028 Reset asserted mid-frame or mid-sync pulse takes effect on the next edge, with no partial pulse completion; hs/vs go high immediately at that edge.

Verification
REQ-029 Release reset, run 800 clocks -> DrawX sequence 0..799 then 0, DrawY steps 0->1 exactly at the wrap, line_start high only at DrawX=0.
REQ-030 Count clocks with blank=1 over one full frame -> exactly 307200; blank=0 for all DrawX>=640 and for all DrawY>=480.
REQ-031 With PIPE_DELAY=1, measure hs -> low from the clock after DrawX=656 through the clock after DrawX=751 (96 clocks); repeat with PIPE_DELAY=3 -> shift of 3 clocks.
REQ-032 Run two full frames (2x420000 clocks) -> vs low for 1600 clocks per frame starting after DrawY=490,DrawX=0; frame_count = 2; frame_start pulses exactly twice after the initial one.
REQ-033 Assert reset_n low for 1 clock while DrawY=491 and hs low -> next edge hs=1, vs=1, DrawX=0, DrawY=0, frame_count=0; timing restarts cleanly.
REQ-034 Force frame_count to 65535 via a short-frame parameter set (H/V totals of 8/4), run one more frame -> frame_count=0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, display enable, start-of-line/frame strobes,
// frame counter and active-low syncs delayed to match the downstream colour pipeline.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 1
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0]            h_cnt_reg, h_cnt_next;
  logic [9:0]            v_cnt_reg, v_cnt_next;
  logic                  run_reg;
  logic                  blank_reg;
  logic                  line_start_reg;
  logic                  frame_start_reg;
  logic [15:0]           frame_count_reg;
  logic [PIPE_DELAY-1:0] hs_pipe_reg;
  logic [PIPE_DELAY-1:0] vs_pipe_reg;
  logic                  h_wrap, v_wrap;
  logic                  hs_raw, vs_raw;

  // The first edge after reset holds the counters at (0,0) so that position is
  // presented with its strobes before counting starts.
  always_comb begin
    h_wrap     = (h_cnt_reg == H_LAST);
    v_wrap     = (v_cnt_reg == V_LAST);
    h_cnt_next = h_cnt_reg;
    v_cnt_next = v_cnt_reg;
    if (run_reg) begin
      h_cnt_next = h_wrap ? 10'd0 : h_cnt_reg + 10'd1;
      if (h_wrap) begin
        v_cnt_next = v_wrap ? 10'd0 : v_cnt_reg + 10'd1;
      end
    end
    hs_raw = !((h_cnt_reg >= HS_START) && (h_cnt_reg < HS_END));
    vs_raw = !((v_cnt_reg >= VS_START) && (v_cnt_reg < VS_END));
  end

  // Decoded outputs are registered from the next counter values so they line up
  // with DrawX/DrawY and can be forced low during reset.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      run_reg         <= 1'b0;
      h_cnt_reg       <= '0;
      v_cnt_reg       <= '0;
      blank_reg       <= 1'b0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      frame_count_reg <= '0;
      hs_pipe_reg     <= '1;
      vs_pipe_reg     <= '1;
    end else begin
      run_reg         <= 1'b1;
      h_cnt_reg       <= h_cnt_next;
      v_cnt_reg       <= v_cnt_next;
      blank_reg       <= (h_cnt_next < H_VIS) && (v_cnt_next < V_VIS);
      line_start_reg  <= (h_cnt_next == 10'd0);
      frame_start_reg <= (h_cnt_next == 10'd0) && (v_cnt_next == 10'd0);
      if (run_reg && h_wrap && v_wrap) begin
        frame_count_reg <= frame_count_reg + 16'd1;
      end
      hs_pipe_reg[0] <= hs_raw;
      vs_pipe_reg[0] <= vs_raw;
      for (int i = 1; i < PIPE_DELAY; i++) begin
        hs_pipe_reg[i] <= hs_pipe_reg[i-1];
        vs_pipe_reg[i] <= vs_pipe_reg[i-1];
      end
    end
  end

  assign DrawX       = h_cnt_reg;
  assign DrawY       = v_cnt_reg;
  assign blank       = blank_reg;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;
  assign frame_count = frame_count_reg;
  assign hs          = hs_pipe_reg[PIPE_DELAY-1];
  assign vs          = vs_pipe_reg[PIPE_DELAY-1];

endmodule
